// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and EX operand select with MEM/WB forwarding and load-use bubbles.
// Optional ID_EX_FWD_EN: when undefined, operands are never forwarded and RAW hazards stall instead.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_id_valid,
  input  logic [WIDTH-1:0] i_id_rs_data,
  input  logic [WIDTH-1:0] i_id_rt_data,
  input  logic [WIDTH-1:0] i_id_imm,
  input  logic [RADDR-1:0] i_id_rs_addr,
  input  logic [RADDR-1:0] i_id_rt_addr,
  input  logic [RADDR-1:0] i_id_rd_addr,
  input  logic [4:0]       i_id_shamt,
  input  logic [3:0]       i_id_alu_ctrl,
  input  logic             i_id_alu_src,
  input  logic             i_id_shift_imm,
  input  logic             i_id_uses_rt,
  input  logic             i_id_reg_write,
  input  logic             i_id_mem_read,
  input  logic             i_id_mem_write,
  input  logic             i_id_mem_to_reg,
  input  logic             i_mem_reg_write,
  input  logic [RADDR-1:0] i_mem_rd_addr,
  input  logic [WIDTH-1:0] i_mem_result,
  input  logic             i_wb_reg_write,
  input  logic [RADDR-1:0] i_wb_rd_addr,
  input  logic [WIDTH-1:0] i_wb_result,
  output logic [WIDTH-1:0] o_src1,
  output logic [WIDTH-1:0] o_alu_mux,
  output logic [3:0]       o_alu_ctrl,
  output logic [WIDTH-1:0] o_store_data,
  output logic             o_ex_valid,
  output logic             o_ex_reg_write,
  output logic             o_ex_mem_read,
  output logic             o_ex_mem_write,
  output logic             o_ex_mem_to_reg,
  output logic [RADDR-1:0] o_ex_rd_addr,
  output logic             o_hazard_stall
);
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm;
    logic [RADDR-1:0] rs_addr;
    logic [RADDR-1:0] rt_addr;
    logic [RADDR-1:0] rd_addr;
    logic [4:0]       shamt;
    logic [3:0]       alu_ctrl;
    logic             alu_src;
    logic             shift_imm;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
  } ex_t;

  ex_t ex, id;

  always_comb begin
    id.valid      = i_id_valid;
    id.rs_data    = i_id_rs_data;
    id.rt_data    = i_id_rt_data;
    id.imm        = i_id_imm;
    id.rs_addr    = i_id_rs_addr;
    id.rt_addr    = i_id_rt_addr;
    id.rd_addr    = i_id_rd_addr;
    id.shamt      = i_id_shamt;
    id.alu_ctrl   = i_id_alu_ctrl;
    id.alu_src    = i_id_alu_src;
    id.shift_imm  = i_id_shift_imm;
    id.reg_write  = i_id_reg_write;
    id.mem_read   = i_id_mem_read;
    id.mem_write  = i_id_mem_write;
    id.mem_to_reg = i_id_mem_to_reg;
  end

  // ID source match against a writer's destination; register 0 never creates a dependency
  logic ex_hit, load_use, raw;
  assign ex_hit   = (ex.rd_addr != '0) &&
                    (ex.rd_addr == i_id_rs_addr || (i_id_uses_rt && ex.rd_addr == i_id_rt_addr));
  assign load_use = ex.valid & ex.mem_read & ex_hit;

  logic [1:0][RADDR-1:0] src_addr;
  logic [1:0][WIDTH-1:0] src_data, fwd;
  assign src_addr = {ex.rt_addr, ex.rs_addr};
  assign src_data = {ex.rt_data, ex.rs_data};

`ifdef ID_EX_FWD_EN
  assign raw = load_use;

  for (genvar s = 0; s < 2; s++) begin : g_fwd
    logic mem_m, wb_m;
    assign mem_m  = i_mem_reg_write && i_mem_rd_addr != '0 && i_mem_rd_addr == src_addr[s];
    assign wb_m   = i_wb_reg_write  && i_wb_rd_addr  != '0 && i_wb_rd_addr  == src_addr[s];
    assign fwd[s] = mem_m ? i_mem_result : (wb_m ? i_wb_result : src_data[s]);
  end
`else
  logic mem_hit;
  assign mem_hit = i_mem_reg_write && (i_mem_rd_addr != '0) &&
                   (i_mem_rd_addr == i_id_rs_addr || (i_id_uses_rt && i_mem_rd_addr == i_id_rt_addr));
  // WB needs no stall: the register file is write-first
  assign raw = load_use | (ex.valid & ex.reg_write & ex_hit) | mem_hit;

  for (genvar s = 0; s < 2; s++) begin : g_fwd
    assign fwd[s] = src_data[s];
  end

  logic unused_nofwd;
  assign unused_nofwd = ^{i_mem_result, i_wb_reg_write, i_wb_rd_addr, i_wb_result, src_addr};
`endif

  assign o_hazard_stall = i_id_valid & raw & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            ex <= '0;
    else if (i_flush)        ex <= '0;
    else if (i_stall)        ex <= ex;
    else if (o_hazard_stall) ex <= '0;
    else                     ex <= id;
  end

  assign o_src1          = ex.shift_imm ? fwd[1] : fwd[0];
  assign o_alu_mux       = ex.shift_imm ? {{(WIDTH-5){1'b0}}, ex.shamt} :
                           (ex.alu_src ? ex.imm : fwd[1]);
  assign o_store_data    = fwd[1];
  assign o_alu_ctrl      = ex.alu_ctrl;
  assign o_ex_valid      = ex.valid;
  assign o_ex_reg_write  = ex.reg_write;
  assign o_ex_mem_read   = ex.mem_read;
  assign o_ex_mem_write  = ex.mem_write;
  assign o_ex_mem_to_reg = ex.mem_to_reg;
  assign o_ex_rd_addr    = ex.rd_addr;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: behavioural EX-slot model checked every cycle plus literal pins.
module tb_id_ex_stage;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic i_clk, i_rst_n, i_stall, i_flush, i_id_valid;
  logic [31:0] i_id_rs_data, i_id_rt_data, i_id_imm;
  logic [4:0]  i_id_rs_addr, i_id_rt_addr, i_id_rd_addr, i_id_shamt;
  logic [3:0]  i_id_alu_ctrl;
  logic i_id_alu_src, i_id_shift_imm, i_id_uses_rt;
  logic i_id_reg_write, i_id_mem_read, i_id_mem_write, i_id_mem_to_reg;
  logic i_mem_reg_write, i_wb_reg_write;
  logic [4:0]  i_mem_rd_addr, i_wb_rd_addr;
  logic [31:0] i_mem_result, i_wb_result;
  logic [31:0] o_src1, o_alu_mux, o_store_data;
  logic [3:0]  o_alu_ctrl;
  logic o_ex_valid, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_mem_to_reg;
  logic [4:0]  o_ex_rd_addr;
  logic o_hazard_stall;

  int n_chk = 0;
  int n_fail = 0;

  id_ex_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_id_valid(i_id_valid), .i_id_rs_data(i_id_rs_data), .i_id_rt_data(i_id_rt_data),
    .i_id_imm(i_id_imm), .i_id_rs_addr(i_id_rs_addr), .i_id_rt_addr(i_id_rt_addr),
    .i_id_rd_addr(i_id_rd_addr), .i_id_shamt(i_id_shamt), .i_id_alu_ctrl(i_id_alu_ctrl),
    .i_id_alu_src(i_id_alu_src), .i_id_shift_imm(i_id_shift_imm), .i_id_uses_rt(i_id_uses_rt),
    .i_id_reg_write(i_id_reg_write), .i_id_mem_read(i_id_mem_read),
    .i_id_mem_write(i_id_mem_write), .i_id_mem_to_reg(i_id_mem_to_reg),
    .i_mem_reg_write(i_mem_reg_write), .i_mem_rd_addr(i_mem_rd_addr), .i_mem_result(i_mem_result),
    .i_wb_reg_write(i_wb_reg_write), .i_wb_rd_addr(i_wb_rd_addr), .i_wb_result(i_wb_result),
    .o_src1(o_src1), .o_alu_mux(o_alu_mux), .o_alu_ctrl(o_alu_ctrl), .o_store_data(o_store_data),
    .o_ex_valid(o_ex_valid), .o_ex_reg_write(o_ex_reg_write), .o_ex_mem_read(o_ex_mem_read),
    .o_ex_mem_write(o_ex_mem_write), .o_ex_mem_to_reg(o_ex_mem_to_reg),
    .o_ex_rd_addr(o_ex_rd_addr), .o_hazard_stall(o_hazard_stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the EX slot holds, kept as a plain record of the instruction that entered it
  typedef struct packed {
    logic v;
    logic [31:0] rsd, rtd, imm;
    logic [4:0] rs, rt, rd, shamt;
    logic [3:0] ctrl;
    logic asrc, shimm, rw, mr, mw, m2r;
  } slot_t;
  slot_t m = '0;

  function automatic logic [31:0] fwd_val(input logic [4:0] a, input logic [31:0] d);
`ifdef ID_EX_FWD_EN
    if (a != 5'd0 && i_mem_reg_write && i_mem_rd_addr == a) return i_mem_result;
    if (a != 5'd0 && i_wb_reg_write && i_wb_rd_addr == a) return i_wb_result;
`endif
    return d;
  endfunction

  function automatic bit id_reads(input logic [4:0] r);
    return i_id_valid && r != 5'd0 && (r == i_id_rs_addr || (i_id_uses_rt && r == i_id_rt_addr));
  endfunction

  function automatic bit model_haz();
    bit h;
    h = m.v && m.mr && id_reads(m.rd);
`ifndef ID_EX_FWD_EN
    h = h || (m.v && m.rw && id_reads(m.rd)) || (i_mem_reg_write && id_reads(i_mem_rd_addr));
`endif
    return h && !i_flush;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) m <= '0;
    else if (i_flush) m <= '0;
    else if (!i_stall) begin
      if (model_haz()) m <= '0;
      else m <= '{v: i_id_valid, rsd: i_id_rs_data, rtd: i_id_rt_data, imm: i_id_imm,
                  rs: i_id_rs_addr, rt: i_id_rt_addr, rd: i_id_rd_addr, shamt: i_id_shamt,
                  ctrl: i_id_alu_ctrl, asrc: i_id_alu_src, shimm: i_id_shift_imm,
                  rw: i_id_reg_write, mr: i_id_mem_read, mw: i_id_mem_write, m2r: i_id_mem_to_reg};
    end
  end

  always @(negedge i_clk) begin
    check("m_valid", 32'(o_ex_valid), 32'(m.v));
    check("m_reg_write", 32'(o_ex_reg_write), 32'(m.rw));
    check("m_mem_read", 32'(o_ex_mem_read), 32'(m.mr));
    check("m_mem_write", 32'(o_ex_mem_write), 32'(m.mw));
    check("m_mem_to_reg", 32'(o_ex_mem_to_reg), 32'(m.m2r));
    check("m_rd", 32'(o_ex_rd_addr), 32'(m.rd));
    check("m_alu_ctrl", 32'(o_alu_ctrl), 32'(m.ctrl));
    check("m_src1", o_src1, m.shimm ? fwd_val(m.rt, m.rtd) : fwd_val(m.rs, m.rsd));
    check("m_alu_mux", o_alu_mux,
          m.shimm ? {27'd0, m.shamt} : (m.asrc ? m.imm : fwd_val(m.rt, m.rtd)));
    check("m_store", o_store_data, fwd_val(m.rt, m.rtd));
    check("m_hazard", 32'(o_hazard_stall), 32'(model_haz()));
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_id_valid = 0; i_id_rs_data = '0; i_id_rt_data = '0; i_id_imm = '0;
    i_id_rs_addr = '0; i_id_rt_addr = '0; i_id_rd_addr = '0; i_id_shamt = '0;
    i_id_alu_ctrl = '0; i_id_alu_src = 0; i_id_shift_imm = 0; i_id_uses_rt = 0;
    i_id_reg_write = 0; i_id_mem_read = 0; i_id_mem_write = 0; i_id_mem_to_reg = 0;
  endtask

  task automatic clear_fwd();
    i_mem_reg_write = 0; i_mem_rd_addr = '0; i_mem_result = '0;
    i_wb_reg_write = 0; i_wb_rd_addr = '0; i_wb_result = '0;
  endtask

  task automatic op_r(input int rs, input int rt, input int rd,
                      input logic [31:0] rsd, input logic [31:0] rtd, input int ctrl);
    idle();
    i_id_valid = 1; i_id_rs_addr = 5'(rs); i_id_rt_addr = 5'(rt); i_id_rd_addr = 5'(rd);
    i_id_rs_data = rsd; i_id_rt_data = rtd; i_id_alu_ctrl = 4'(ctrl);
    i_id_uses_rt = 1; i_id_reg_write = 1;
  endtask

  task automatic op_i(input int rs, input int rd, input logic [31:0] rsd, input logic [31:0] imm);
    idle();
    i_id_valid = 1; i_id_rs_addr = 5'(rs); i_id_rt_addr = 5'(rd); i_id_rd_addr = 5'(rd);
    i_id_rs_data = rsd; i_id_imm = imm; i_id_alu_ctrl = 4'd2; i_id_alu_src = 1; i_id_reg_write = 1;
  endtask

  task automatic op_lw(input int rs, input int rd, input logic [31:0] rsd, input logic [31:0] imm);
    op_i(rs, rd, rsd, imm);
    i_id_mem_read = 1; i_id_mem_to_reg = 1;
  endtask

  task automatic op_sll(input int rt, input int rd, input logic [31:0] rtd, input int sh);
    idle();
    i_id_valid = 1; i_id_rt_addr = 5'(rt); i_id_rd_addr = 5'(rd); i_id_rt_data = rtd;
    i_id_shamt = 5'(sh); i_id_alu_ctrl = 4'd8; i_id_shift_imm = 1; i_id_uses_rt = 1;
    i_id_reg_write = 1;
  endtask

  initial begin
    i_rst_n = 0; i_stall = 0; i_flush = 0;
    idle(); clear_fwd();
    repeat (2) step();
    check("reset_valid", 32'(o_ex_valid), 32'd0);
    check("reset_src1", o_src1, 32'd0);
    check("reset_hazard", 32'(o_hazard_stall), 32'd0);

    // release and first load
    i_rst_n = 1;
    op_r(3, 4, 5, 32'd5, 32'd7, 2);
    step();
    check("add_src1", o_src1, 32'd5);
    check("add_mux", o_alu_mux, 32'd7);
    check("add_valid", 32'(o_ex_valid), 32'd1);
    check("add_rd", 32'(o_ex_rd_addr), 32'd5);

    // asynchronous reset mid-run clears immediately
    i_rst_n = 0; #1;
    check("midrst_valid", 32'(o_ex_valid), 32'd0);
    check("midrst_src1", o_src1, 32'd0);
    check("midrst_mux", o_alu_mux, 32'd0);
    check("midrst_rd", 32'(o_ex_rd_addr), 32'd0);
    step(); i_rst_n = 1;
    step();
    check("rel_src1", o_src1, 32'd5);
    check("rel_mux", o_alu_mux, 32'd7);

    // forwarding priority MEM > WB > register data
    op_r(3, 3, 6, 32'h99, 32'h77, 0);
    step();
    idle();
    i_mem_reg_write = 1; i_mem_rd_addr = 5'd3; i_mem_result = 32'h10;
    i_wb_reg_write = 1; i_wb_rd_addr = 5'd3; i_wb_result = 32'h20; #1;
    check("fwd_mem_src1", o_src1, FWD ? 32'h10 : 32'h99);
    check("fwd_mem_store", o_store_data, FWD ? 32'h10 : 32'h77);
    i_mem_reg_write = 0; #1;
    check("fwd_wb_src1", o_src1, FWD ? 32'h20 : 32'h99);
    i_mem_reg_write = 1; i_mem_rd_addr = 5'd0; i_wb_rd_addr = 5'd0; #1;
    check("fwd_r0_src1", o_src1, 32'h99);
    step();

    // load-use: one bubble, then the add picks up the loaded value
    clear_fwd();
    op_lw(1, 2, 32'h100, 32'h4);
    step();
    op_r(2, 4, 7, 32'hDEAD, 32'h3, 2); #1;
    check("lu_hazard", 32'(o_hazard_stall), 32'd1);
    step();
    check("lu_bubble", 32'(o_ex_valid), 32'd0);
    i_mem_reg_write = 1; i_mem_rd_addr = 5'd2; i_mem_result = 32'h55; #1;
`ifdef ID_EX_FWD_EN
    check("lu_clear", 32'(o_hazard_stall), 32'd0);
`else
    check("lu_raw_mem", 32'(o_hazard_stall), 32'd1);
    step();
    clear_fwd();
    i_wb_reg_write = 1; i_wb_rd_addr = 5'd2; i_wb_result = 32'h55;
    op_r(2, 4, 7, 32'h55, 32'h3, 2); #1;
    check("lu_clear", 32'(o_hazard_stall), 32'd0);
`endif
    step();
    check("lu_add_src1", o_src1, 32'h55);
    check("lu_add_valid", 32'(o_ex_valid), 32'd1);

    // stall beats load-use bubble; hazard stays up while held
    clear_fwd();
    op_lw(1, 2, 32'h100, 32'h8);
    step();
    op_r(2, 4, 7, 32'h1, 32'h3, 2);
    i_stall = 1; #1;
    check("slu_hazard", 32'(o_hazard_stall), 32'd1);
    step();
    check("slu_hold_mr", 32'(o_ex_mem_read), 32'd1);
    check("slu_hazard2", 32'(o_hazard_stall), 32'd1);
    i_stall = 0;
    step();
    check("slu_bubble", 32'(o_ex_valid), 32'd0);
    idle();
    step();

    // shift-immediate and sign-extended immediate operands
    op_sll(9, 8, 32'h1, 4);
    step();
    check("sll_src1", o_src1, 32'h1);
    check("sll_mux", o_alu_mux, 32'h4);
    op_i(0, 8, 32'h0, 32'hFFFF_FFFF);
    step();
    check("addi_mux", o_alu_mux, 32'hFFFF_FFFF);

    // flush with stall loads a bubble
    op_r(10, 11, 12, 32'hA, 32'hB, 3);
    i_stall = 1; i_flush = 1;
    step();
    check("fl_valid", 32'(o_ex_valid), 32'd0);
    check("fl_ctrl", 32'(o_alu_ctrl), 32'd0);
    check("fl_rd", 32'(o_ex_rd_addr), 32'd0);
    i_stall = 0; i_flush = 0;
    step();
    check("ld_src1", o_src1, 32'hA);
    op_r(13, 14, 15, 32'h1, 32'h2, 5);
    i_stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("st_src1", o_src1, 32'hA);
      check("st_rd", 32'(o_ex_rd_addr), 32'd12);
      check("st_ctrl", 32'(o_alu_ctrl), 32'd3);
    end
    i_stall = 0;
    idle();
    step();

    // flush masks a load-use hazard
    op_lw(1, 2, 32'h0, 32'h0);
    step();
    op_r(2, 2, 3, 32'h0, 32'h0, 2);
    i_flush = 1; #1;
    check("flu_hazard", 32'(o_hazard_stall), 32'd0);
    step();
    check("flu_valid", 32'(o_ex_valid), 32'd0);
    i_flush = 0;
    idle();
    step();

    // ALU writer r5 followed by a reader of r5
    op_r(1, 1, 5, 32'h3, 32'h3, 2);
    step();
    op_r(5, 6, 9, 32'h3, 32'h4, 2); #1;
    check("raw_ex_hazard", 32'(o_hazard_stall), FWD ? 32'd0 : 32'd1);
`ifndef ID_EX_FWD_EN
    step();
    check("raw_bubble", 32'(o_ex_valid), 32'd0);
    i_mem_reg_write = 1; i_mem_rd_addr = 5'd5; i_mem_result = 32'h6; #1;
    check("raw_mem_hazard", 32'(o_hazard_stall), 32'd1);
    step();
    clear_fwd();
    i_wb_reg_write = 1; i_wb_rd_addr = 5'd5; i_wb_result = 32'h6; #1;
    check("raw_wb_hazard", 32'(o_hazard_stall), 32'd0);
`endif
    step();
    check("raw_enter", 32'(o_ex_valid), 32'd1);
    check("raw_rd", 32'(o_ex_rd_addr), 32'd9);
    idle(); clear_fwd();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
